// File: rtl/numlock_pkg.sv
// Shared definitions for the numlock code transmitter and detector:
// one-hot state encodings, the default unlock code and the symbol-to-key mapping.
package numlock_pkg;

    localparam int ST_W = 6;

    localparam logic [ST_W-1:0] ST_IDLE     = 6'b000001;
    localparam logic [ST_W-1:0] ST_PRESS    = 6'b000010;
    localparam logic [ST_W-1:0] ST_RELEASE  = 6'b000100;
    localparam logic [ST_W-1:0] ST_WAIT_ACK = 6'b001000;
    localparam logic [ST_W-1:0] ST_DONE     = 6'b010000;
    localparam logic [ST_W-1:0] ST_FAIL     = 6'b100000;

    localparam int         NUMLOCK_DEFAULT_LEN  = 4;
    localparam logic [7:0] NUMLOCK_DEFAULT_CODE = 8'b0000_1011;

    // A '1' symbol is a U press, a '0' symbol is a Z press; returns {U, Z}.
    function automatic logic [1:0] sym_to_keys(input logic sym);
        return {sym, ~sym};
    endfunction

endpackage

// File: rtl/numlock_cycle_timer.sv
// Loadable down-counter with a zero flag; shared for press, gap and
// acknowledge-timeout intervals of the numlock transmitter.
module numlock_cycle_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load wins over decrement; the counter parks at zero instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/numlock_code_tx.sv
// Replays a fixed unlock code as timed U/Z presses and waits for Unlock.
// Optional NUMLOCK_TX_RETRY_EN: resend the whole code once after the first ACK timeout.
module numlock_code_tx
    import numlock_pkg::*;
#(
    parameter int         CODE_LEN    = NUMLOCK_DEFAULT_LEN,
    parameter logic [7:0] CODE        = NUMLOCK_DEFAULT_CODE,
    parameter int         PRESS_CYC   = 4,
    parameter int         GAP_CYC     = 4,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic reset,
    input  logic Start,
    input  logic Unlock,
    output logic U,
    output logic Z,
    output logic Busy,
    output logic Done,
    output logic Fail,
    output logic q_Idle,
    output logic q_Press,
    output logic q_Release,
    output logic q_WaitAck,
    output logic q_Done,
    output logic q_Fail
);

    localparam int MAX_PG  = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_PG > ACK_TIMEOUT) ? MAX_PG : ACK_TIMEOUT;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] PRESS_LD = TMR_W'(PRESS_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] ACK_LD   = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       LAST_IDX = 4'(CODE_LEN - 1);

    logic [ST_W-1:0]  r_state;
    logic [3:0]       r_idx;
    logic             r_u;
    logic             r_z;

    logic [ST_W-1:0]  w_next_state;
    logic [3:0]       w_idx_next;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    logic [TMR_W-1:0] w_tmr_count;
    logic [1:0]       w_keys;

`ifdef NUMLOCK_TX_RETRY_EN
    logic r_retry;
    logic w_retry_set;
`endif

    numlock_cycle_timer #(.W(TMR_W)) u_timer (
        .i_clk   (Clk),
        .i_rst   (reset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .i_dec   (w_tmr_dec),
        .o_count (w_tmr_count),
        .o_zero  (w_tmr_zero)
    );

    // Keys are registered from the next state so they line up with the state taps.
    assign w_keys = (w_next_state == ST_PRESS) ? sym_to_keys(CODE[w_idx_next[2:0]]) : 2'b00;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_u     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_idx_next;
            r_u     <= w_keys[1];
            r_z     <= w_keys[0];
        end
    end

`ifdef NUMLOCK_TX_RETRY_EN
    always_ff @(posedge Clk) begin
        if (reset || (r_state == ST_IDLE)) begin
            r_retry <= 1'b0;
        end else if (w_retry_set) begin
            r_retry <= 1'b1;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_idx_next   = r_idx;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_dec    = 1'b0;
`ifdef NUMLOCK_TX_RETRY_EN
        w_retry_set  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_next_state = ST_PRESS;
                    w_idx_next   = LAST_IDX;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = PRESS_LD;
                end
            end
            ST_PRESS: begin
                if (w_tmr_zero) begin
                    w_next_state = ST_RELEASE;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = GAP_LD;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!w_tmr_zero) begin
                    w_tmr_dec = 1'b1;
                end else if (r_idx == '0) begin
                    w_next_state = ST_WAIT_ACK;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = ACK_LD;
                end else begin
                    w_next_state = ST_PRESS;
                    w_idx_next   = r_idx - 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = PRESS_LD;
                end
            end
            ST_WAIT_ACK: begin
                // Unlock beats the timeout when both land in the same cycle.
                if (Unlock) begin
                    w_next_state = ST_DONE;
                end else if (w_tmr_zero) begin
`ifdef NUMLOCK_TX_RETRY_EN
                    if (!r_retry) begin
                        w_next_state = ST_RELEASE;
                        w_idx_next   = 4'(CODE_LEN);
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = GAP_LD;
                        w_retry_set  = 1'b1;
                    end else begin
                        w_next_state = ST_FAIL;
                    end
`else
                    w_next_state = ST_FAIL;
`endif
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_FAIL:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        U         = r_u;
        Z         = r_z;
        Busy      = (r_state != ST_IDLE);
        Done      = (r_state == ST_DONE);
        Fail      = (r_state == ST_FAIL);
        q_Idle    = (r_state == ST_IDLE);
        q_Press   = (r_state == ST_PRESS);
        q_Release = (r_state == ST_RELEASE);
        q_WaitAck = (r_state == ST_WAIT_ACK);
        q_Done    = (r_state == ST_DONE);
        q_Fail    = (r_state == ST_FAIL);
    end

endmodule

// File: tb/tb_numlock_code_tx.sv
// Bench for numlock_code_tx with default parameters; honours NUMLOCK_TX_RETRY_EN.
module tb_numlock_code_tx;

    localparam int         P     = 4;
    localparam int         G     = 4;
    localparam int         A     = 16;
    localparam int         L     = 4;
    localparam int         F     = L * (P + G);
    localparam logic [7:0] CODEV = 8'b0000_1011;
`ifdef NUMLOCK_TX_RETRY_EN
    localparam int NATT = 2;
`else
    localparam int NATT = 1;
`endif

    localparam logic [5:0] S_IDLE = 6'b000001;
    localparam logic [5:0] S_PRS  = 6'b000010;
    localparam logic [5:0] S_REL  = 6'b000100;
    localparam logic [5:0] S_WAIT = 6'b001000;
    localparam logic [5:0] S_DONE = 6'b010000;
    localparam logic [5:0] S_FAIL = 6'b100000;

    logic Clk = 1'b0;
    logic reset, Start, Unlock;
    logic U, Z, Busy, Done, Fail;
    logic q_Idle, q_Press, q_Release, q_WaitAck, q_Done, q_Fail;

    typedef struct packed {
        logic       u;
        logic       z;
        logic       busy;
        logic       done;
        logic       fail;
        logic [5:0] st;
    } exp_t;

    typedef struct {
        int ack;
        int extra;
        int rst;
        int restart;
        int ncyc;
    } vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[7];

    numlock_code_tx dut (
        .Clk       (Clk),
        .reset     (reset),
        .Start     (Start),
        .Unlock    (Unlock),
        .U         (U),
        .Z         (Z),
        .Busy      (Busy),
        .Done      (Done),
        .Fail      (Fail),
        .q_Idle    (q_Idle),
        .q_Press   (q_Press),
        .q_Release (q_Release),
        .q_WaitAck (q_WaitAck),
        .q_Done    (q_Done),
        .q_Fail    (q_Fail)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t st_exp(input logic [5:0] st, input logic u, input logic z);
        exp_t e;
        e.st   = st;
        e.u    = u;
        e.z    = z;
        e.busy = (st != S_IDLE);
        e.done = (st == S_DONE);
        e.fail = (st == S_FAIL);
        return e;
    endfunction

    // t = cycles since the cycle Start was high; ack = cycle Unlock was high.
    function automatic exp_t model(input int t, input int ack);
        int   b;
        int   u;
        int   slot;
        int   pos;
        logic k;
        b = 1;
        if (t < 1) return st_exp(S_IDLE, 1'b0, 1'b0);
        for (int att = 0; att < NATT; att++) begin
            if (t < b) return st_exp(S_REL, 1'b0, 1'b0);
            u = t - b;
            if (u < F) begin
                slot = u / (P + G);
                pos  = u % (P + G);
                if (pos < P) begin
                    k = CODEV[L - 1 - slot];
                    return st_exp(S_PRS, k, ~k);
                end
                return st_exp(S_REL, 1'b0, 1'b0);
            end
            if (ack >= b + F && ack < b + F + A && t > ack)
                return st_exp((t == ack + 1) ? S_DONE : S_IDLE, 1'b0, 1'b0);
            if (u < F + A) return st_exp(S_WAIT, 1'b0, 1'b0);
            if (att == NATT - 1) return st_exp((u == F + A) ? S_FAIL : S_IDLE, 1'b0, 1'b0);
            b = b + F + A + G;
        end
        return st_exp(S_IDLE, 1'b0, 1'b0);
    endfunction

    function automatic exp_t expect_at(input vec_t v, input int c);
        if (v.rst >= 0 && c > v.rst) begin
            if (v.restart >= 0 && c > v.restart) return model(c - v.restart, v.ack - v.restart);
            return st_exp(S_IDLE, 1'b0, 1'b0);
        end
        return model(c, v.ack);
    endfunction

    task automatic compare(input exp_t e, input string tag);
        exp_t a;
        a.u    = U;
        a.z    = Z;
        a.busy = Busy;
        a.done = Done;
        a.fail = Fail;
        a.st   = {q_Fail, q_Done, q_WaitAck, q_Release, q_Press, q_Idle};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got u=%b z=%b busy=%b done=%b fail=%b st=%b want u=%b z=%b busy=%b done=%b fail=%b st=%b",
                     tag, a.u, a.z, a.busy, a.done, a.fail, a.st,
                     e.u, e.z, e.busy, e.done, e.fail, e.st);
        end
        checks++;
        if (U & Z) begin
            failures++;
            $display("FAIL %s_keys got U=%b Z=%b want not both high", tag, U, Z);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge Clk);
        #1;
        reset  = 1'b1;
        Start  = 1'b0;
        Unlock = 1'b0;
        @(posedge Clk);
        #1;
        reset = 1'b0;
        @(negedge Clk);
        compare(st_exp(S_IDLE, 1'b0, 1'b0), tag);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        for (int c = 0; c < v.ncyc; c++) begin
            @(posedge Clk);
            #1;
            Start  = (c == 0) || (c == v.extra) || (c == v.restart);
            Unlock = (c == v.ack);
            reset  = (c == v.rst);
            sb_q.push_back(expect_at(v, c));
            @(negedge Clk);
            compare(sb_q.pop_front(), $sformatf("vec%0d_cyc%0d", idx, c));
        end
        Start  = 1'b0;
        Unlock = 1'b0;
        reset  = 1'b0;
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        Start  = 1'b0;
        Unlock = 1'b0;
        repeat (2) @(posedge Clk);

        //          ack  extra rst  restart ncyc
        vecs[0] = '{-1,  -1,   -1,  -1,     106};  // no Unlock: timeout (and retry)
        vecs[1] = '{35,  -1,   -1,  -1,     40};   // Unlock early in WAIT_ACK
        vecs[2] = '{5,   10,   -1,  -1,     106};  // stray Start/Unlock ignored
        vecs[3] = '{48,  -1,   -1,  -1,     52};   // Unlock on last timer cycle wins
        vecs[4] = '{49,  -1,   -1,  -1,     106};  // Unlock one cycle too late
        vecs[5] = '{-1,  -1,   11,  14,     66};   // reset mid Z press, then fresh run
        vecs[6] = '{40,  -1,   40,  -1,     45};   // reset with Unlock: no Done pulse

        do_reset("reset_state");
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            do_reset($sformatf("reset_after_vec%0d", i));
        end

        // Bounded wait for WAIT_ACK, then acknowledge and expect a single Done.
        @(posedge Clk);
        #1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        n = 0;
        while (!q_WaitAck && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
        checks++;
        if (!q_WaitAck || n != F) begin
            failures++;
            $display("FAIL wait_ack_latency got q_WaitAck=%b after %0d cycles want 1 after %0d", q_WaitAck, n, F);
        end
        Unlock = 1'b1;
        @(posedge Clk);
        #1;
        Unlock = 1'b0;
        checks++;
        if (Done !== 1'b1 || Fail !== 1'b0) begin
            failures++;
            $display("FAIL ack_done got Done=%b Fail=%b want Done=1 Fail=0", Done, Fail);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b0 || q_Idle !== 1'b1) begin
            failures++;
            $display("FAIL ack_idle got Done=%b q_Idle=%b want Done=0 q_Idle=1", Done, q_Idle);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
